// File: rtl/hdmi_timing_pattern_gen.sv
// ---------------------------------------------------------------------------
// hdmi_timing_pattern_gen
//
// Parametrised video timing generator and YCbCr 4:2:2 test-pattern source
// for the HDMI transmitter path. A horizontal/vertical counter pair walks the
// full raster. Every output is registered one cycle after the counter state
// that produced it, so sync, enable and data stay mutually aligned.
//
// Ports
//   pixel_clk    in   pixel clock, all logic on the rising edge
//   reset        in   synchronous reset, active-high
//   mode[1:0]    in   pattern: 0 solid, 1 colour bars, 2 moving ramp,
//                     3 checkerboard (latched at the start of each frame)
//   solid_y/cb/cr in  colour used by mode 0
//   data_enable  out  active-video qualifier
//   hsync/vsync  out  syncs, asserted level set by HS_POL / VS_POL
//   data_Y       out  luma (16 during blanking)
//   data_Cb_Cr   out  Cb on even active pixels, Cr on odd (128 in blanking)
//   frame_start  out  one-cycle pulse with the first active pixel of a frame
//   frame_cnt    out  completed frames, wraps modulo 2^FCNT_W
// ---------------------------------------------------------------------------
module hdmi_timing_pattern_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int CHK_LOG2 = 5,
   parameter int FCNT_W   = 16
) (
   input  logic              pixel_clk,
   input  logic              reset,
   input  logic [1:0]        mode,
   input  logic [7:0]        solid_y,
   input  logic [7:0]        solid_cb,
   input  logic [7:0]        solid_cr,
   output logic              data_enable,
   output logic              hsync,
   output logic              vsync,
   output logic [7:0]        data_Y,
   output logic [7:0]        data_Cb_Cr,
   output logic              frame_start,
   output logic [FCNT_W-1:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // One spare code so every boundary constant (up to the total) fits.
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [BW-1:0] BAR_LOAD = BW'(BAR_W - 1);

   // Raster position and per-frame state
   logic [HW-1:0]     h_cnt_q, h_cnt_d;
   logic [VW-1:0]     v_cnt_q, v_cnt_d;
   logic [1:0]        mode_q, mode_d;
   logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [2:0]        bar_idx_q, bar_idx_d;
   logic [BW-1:0]     bar_cnt_q, bar_cnt_d;
   logic [7:0]        cr_hold_q, cr_hold_d;

   // Registered outputs
   logic       de_q, de_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic [7:0] y_q, y_d;
   logic [7:0] c_q, c_d;
   logic       fs_q, fs_d;

   logic       line_end, frame_end, frame_first, active, chk_bit;
   logic [1:0] mode_eff;
   logic [7:0] pix_y, pix_cb, pix_cr;

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = {8'd180, 8'd128, 8'd128};
         3'd1:    c = {8'd162, 8'd44,  8'd142};
         3'd2:    c = {8'd131, 8'd156, 8'd44 };
         3'd3:    c = {8'd112, 8'd72,  8'd58 };
         3'd4:    c = {8'd84,  8'd184, 8'd198};
         3'd5:    c = {8'd65,  8'd100, 8'd212};
         3'd6:    c = {8'd35,  8'd212, 8'd114};
         default: c = {8'd16,  8'd128, 8'd128};
      endcase
      return c;
   endfunction

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         mode_q      <= 2'd0;
         frame_cnt_q <= '0;
         bar_idx_q   <= 3'd0;
         bar_cnt_q   <= BAR_LOAD;
         cr_hold_q   <= 8'h80;
         de_q        <= 1'b0;
         hs_q        <= ~HS_POL;
         vs_q        <= ~VS_POL;
         y_q         <= 8'h10;
         c_q         <= 8'h80;
         fs_q        <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         mode_q      <= mode_d;
         frame_cnt_q <= frame_cnt_d;
         bar_idx_q   <= bar_idx_d;
         bar_cnt_q   <= bar_cnt_d;
         cr_hold_q   <= cr_hold_d;
         de_q        <= de_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         y_q         <= y_d;
         c_q         <= c_d;
         fs_q        <= fs_d;
      end
   end

   // Raster counters, frame counter, mode latch and bar tracker
   always_comb begin
      line_end    = (h_cnt_q == H_LAST);
      frame_end   = line_end && (v_cnt_q == V_LAST);
      frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);

      h_cnt_d = line_end ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (line_end) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end

      // The new mode already governs the pixel at which it is sampled.
      mode_eff    = frame_first ? mode : mode_q;
      mode_d      = mode_eff;
      frame_cnt_d = frame_end ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;

      // Bar tracker describes the pixel at h_cnt: a down-counter reloads
      // at each bar edge; the last bar absorbs any H_ACTIVE mod 8 residue.
      bar_idx_d = bar_idx_q;
      bar_cnt_d = bar_cnt_q;
      if (line_end) begin
         bar_idx_d = 3'd0;
         bar_cnt_d = BAR_LOAD;
      end else if (bar_cnt_q == '0) begin
         if (bar_idx_q != 3'd7) begin
            bar_idx_d = bar_idx_q + 3'd1;
            bar_cnt_d = BAR_LOAD;
         end
      end else begin
         bar_cnt_d = bar_cnt_q - BW'(1);
      end
   end

   assign chk_bit = 1'((32'(h_cnt_q) ^ 32'(v_cnt_q)) >> CHK_LOG2);

   // Pixel colour and registered output values
   always_comb begin
      pix_y  = 8'h10;
      pix_cb = 8'h80;
      pix_cr = 8'h80;
      case (mode_eff)
         2'd0: begin
            pix_y  = solid_y;
            pix_cb = solid_cb;
            pix_cr = solid_cr;
         end
         2'd1:    {pix_y, pix_cb, pix_cr} = bar_colour(bar_idx_q);
         2'd2:    pix_y = 8'(h_cnt_q) + 8'(frame_cnt_q);
         default: pix_y = chk_bit ? 8'd235 : 8'd16;
      endcase

      active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

      // Chroma pair is taken from the even pixel; Cr is held for the odd one.
      cr_hold_d = h_cnt_q[0] ? cr_hold_q : pix_cr;

      de_d = active;
      hs_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
      vs_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
      y_d  = active ? pix_y : 8'h10;
      c_d  = active ? (h_cnt_q[0] ? cr_hold_q : pix_cb) : 8'h80;
      fs_d = active && frame_first;
   end

   assign data_enable = de_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign data_Y      = y_q;
   assign data_Cb_Cr  = c_q;
   assign frame_start = fs_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_timing_pattern_gen.sv
module tb_hdmi_timing_pattern_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [1:0] mode;
   logic [7:0] sy, scb, scr;

   // main instance: positive polarity, 16-bit frame counter
   logic m_de, m_hs, m_vs, m_fs;
   logic [7:0] m_y, m_c;
   logic [15:0] m_fc;
   // 2-bit frame counter instance
   logic f_de, f_hs, f_vs, f_fs;
   logic [7:0] f_y, f_c;
   logic [1:0] f_fc;
   // negative polarity instance
   logic p_de, p_hs, p_vs, p_fs;
   logic [7:0] p_y, p_c;
   logic [15:0] p_fc;

   hdmi_timing_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CHK_LOG2(1), .FCNT_W(16)
   ) u_main (
      .pixel_clk(clk), .reset(reset), .mode(mode),
      .solid_y(sy), .solid_cb(scb), .solid_cr(scr),
      .data_enable(m_de), .hsync(m_hs), .vsync(m_vs),
      .data_Y(m_y), .data_Cb_Cr(m_c), .frame_start(m_fs), .frame_cnt(m_fc)
   );

   hdmi_timing_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CHK_LOG2(1), .FCNT_W(2)
   ) u_f2 (
      .pixel_clk(clk), .reset(reset), .mode(mode),
      .solid_y(sy), .solid_cb(scb), .solid_cr(scr),
      .data_enable(f_de), .hsync(f_hs), .vsync(f_vs),
      .data_Y(f_y), .data_Cb_Cr(f_c), .frame_start(f_fs), .frame_cnt(f_fc)
   );

   hdmi_timing_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CHK_LOG2(1), .FCNT_W(16)
   ) u_pol0 (
      .pixel_clk(clk), .reset(reset), .mode(mode),
      .solid_y(sy), .solid_cb(scb), .solid_cr(scr),
      .data_enable(p_de), .hsync(p_hs), .vsync(p_vs),
      .data_Y(p_y), .data_Cb_Cr(p_c), .frame_start(p_fs), .frame_cnt(p_fc)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: position-based arithmetic over a 24x8 raster
   // ------------------------------------------------------------------
   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [7:0] y;
      logic [7:0] c;
      logic       fs;
   } vid_t;

   int BAR_Y  [8] = '{180, 162, 131, 112, 84, 65, 35, 16};
   int BAR_CB [8] = '{128, 44, 156, 72, 184, 100, 212, 128};
   int BAR_CR [8] = '{128, 142, 44, 58, 198, 212, 114, 128};

   function automatic int pix_y(int h, int v, int n, int md);
      case (md)
         0: return int'(sy);
         1: return BAR_Y[h / 2];
         2: return (h + n) % 256;
         default: return (((h / 2) % 2) != ((v / 2) % 2)) ? 235 : 16;
      endcase
   endfunction

   function automatic int pix_cb(int h, int md);
      case (md)
         0: return int'(scb);
         1: return BAR_CB[h / 2];
         default: return 128;
      endcase
   endfunction

   function automatic int pix_cr(int h, int md);
      case (md)
         0: return int'(scr);
         1: return BAR_CR[h / 2];
         default: return 128;
      endcase
   endfunction

   function automatic vid_t model_px(int pos, int md, bit hpol, bit vpol, int fmod);
      vid_t r;
      int h, v, n;
      h = pos % 24;
      v = (pos / 24) % 8;
      n = (pos / 192) % fmod;
      r.de = (h < 16) && (v < 4);
      r.hs = (h >= 18 && h < 22) ? hpol : ~hpol;
      r.vs = (v >= 5 && v < 7) ? vpol : ~vpol;
      r.fs = (h == 0) && (v == 0);
      if (r.de) begin
         r.y = 8'(pix_y(h, v, n, md));
         r.c = (h % 2 == 0) ? 8'(pix_cb(h, md)) : 8'(pix_cr(h - 1, md));
      end else begin
         r.y = 8'h10;
         r.c = 8'h80;
      end
      return r;
   endfunction

   int mpos   = 0;
   bit mvalid = 1'b0;
   int mmode  = 0;

   always @(posedge clk) begin : cmp
      vid_t em, ef, ep;
      int   efc, p;
      if (reset === 1'b1) begin
         em = {1'b0, 1'b0, 1'b0, 8'h10, 8'h80, 1'b0};
         ef = em;
         ep = {1'b0, 1'b1, 1'b1, 8'h10, 8'h80, 1'b0};
         efc = 0;
         p = -1;
         mpos = 0;
         mvalid = 1'b1;
      end else if (mvalid) begin
         p = mpos;
         if (mpos % 192 == 0) mmode = int'(mode);
         em = model_px(mpos, mmode, 1'b1, 1'b1, 65536);
         ef = model_px(mpos, mmode, 1'b1, 1'b1, 4);
         ep = model_px(mpos, mmode, 1'b0, 1'b0, 65536);
         efc = (mpos + 1) / 192;
         mpos++;
      end
      #1;
      if (mvalid) begin
         total++;
         if ({m_de, m_hs, m_vs, m_y, m_c, m_fs} !== em || m_fc !== 16'(efc)) begin
            bad++;
            $display("FAIL model_main pos=%0d got de=%b hs=%b vs=%b y=%0d c=%0d fs=%b fc=%0d exp de=%b hs=%b vs=%b y=%0d c=%0d fs=%b fc=%0d",
                     p, m_de, m_hs, m_vs, m_y, m_c, m_fs, m_fc, em.de, em.hs, em.vs, em.y, em.c, em.fs, efc % 65536);
         end
         total++;
         if ({f_de, f_hs, f_vs, f_y, f_c, f_fs} !== ef || f_fc !== 2'(efc)) begin
            bad++;
            $display("FAIL model_fcnt2 pos=%0d got de=%b hs=%b vs=%b y=%0d c=%0d fs=%b fc=%0d exp de=%b hs=%b vs=%b y=%0d c=%0d fs=%b fc=%0d",
                     p, f_de, f_hs, f_vs, f_y, f_c, f_fs, f_fc, ef.de, ef.hs, ef.vs, ef.y, ef.c, ef.fs, efc % 4);
         end
         total++;
         if ({p_de, p_hs, p_vs, p_y, p_c, p_fs} !== ep || p_fc !== 16'(efc)) begin
            bad++;
            $display("FAIL model_pol0 pos=%0d got de=%b hs=%b vs=%b y=%0d c=%0d fs=%b fc=%0d exp de=%b hs=%b vs=%b y=%0d c=%0d fs=%b fc=%0d",
                     p, p_de, p_hs, p_vs, p_y, p_c, p_fs, p_fc, ep.de, ep.hs, ep.vs, ep.y, ep.c, ep.fs, efc % 65536);
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed helpers
   // ------------------------------------------------------------------
   logic [7:0] cap_y [64];
   logic [7:0] cap_c [64];

   task automatic wait_fs(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (m_fs === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL wait_fs: got no frame_start within 400 cycles, required one");
      end
   endtask

   task automatic capture_frame();
      bit ok;
      int n;
      n = 0;
      wait_fs(ok);
      if (ok) begin
         cap_y[0] = m_y;
         cap_c[0] = m_c;
         n = 1;
         for (int i = 0; i < 200 && n < 64; i++) begin
            @(posedge clk); #1;
            if (m_de === 1'b1) begin
               cap_y[n] = m_y;
               cap_c[n] = m_c;
               n++;
            end
         end
      end
      chk("capture_count", n, 64);
   endtask

   int exp_bar_y [16] = '{180,180,162,162,131,131,112,112,84,84,65,65,35,35,16,16};
   int exp_bar_c [16] = '{128,128,44,142,156,44,72,58,184,198,100,212,212,114,128,128};
   int exp_chk0  [16] = '{16,16,235,235,16,16,235,235,16,16,235,235,16,16,235,235};
   int exp_chk2  [16] = '{235,235,16,16,235,235,16,16,235,235,16,16,235,235,16,16};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit ok;
      int de_n, hs_n, vs_n, fs_n, phs_n, pvs_n;
      int hs_first, vs_first, fs_first, fs_second;
      int gap, solid_n, solid_bad;

      reset = 1'b1;
      mode  = 2'd0;
      sy    = 8'h50;
      scb   = 8'h60;
      scr   = 8'h70;
      repeat (3) @(negedge clk);

      chk("rst_de",     m_de, 0);
      chk("rst_hs",     m_hs, 0);
      chk("rst_vs",     m_vs, 0);
      chk("rst_y",      m_y, 16);
      chk("rst_c",      m_c, 128);
      chk("rst_fs",     m_fs, 0);
      chk("rst_fc",     m_fc, 0);
      chk("rst_pol0_hs", p_hs, 1);
      chk("rst_pol0_vs", p_vs, 1);

      // Timing over two frames
      reset = 1'b0;
      de_n = 0; hs_n = 0; vs_n = 0; fs_n = 0; phs_n = 0; pvs_n = 0;
      hs_first = -1; vs_first = -1; fs_first = -1; fs_second = -1;
      for (int i = 0; i < 384; i++) begin
         @(posedge clk); #1;
         if (m_de === 1'b1) de_n++;
         if (m_hs === 1'b1) begin
            hs_n++;
            if (hs_first < 0) hs_first = i;
         end
         if (m_vs === 1'b1) begin
            vs_n++;
            if (vs_first < 0) vs_first = i;
         end
         if (m_fs === 1'b1) begin
            if (fs_n == 0) fs_first = i;
            if (fs_n == 1) fs_second = i;
            fs_n++;
         end
         if (p_hs === 1'b0) phs_n++;
         if (p_vs === 1'b0) pvs_n++;
      end
      chk("t1_de_count",   de_n, 128);
      chk("t1_hs_count",   hs_n, 64);
      chk("t1_vs_count",   vs_n, 96);
      chk("t1_fs_count",   fs_n, 2);
      chk("t1_hs_first",   hs_first, 18);
      chk("t1_vs_first",   vs_first, 120);
      chk("t1_fs_first",   fs_first, 0);
      chk("t1_fs_period",  fs_second, 192);
      chk("t6_pol0_hs_low", phs_n, 64);
      chk("t6_pol0_vs_low", pvs_n, 96);

      // Reset mid-frame at h_cnt=10, v_cnt=2
      @(negedge clk);
      for (int i = 0; i < 400 && (mpos % 192) != 58; i++) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t2_rst_de", m_de, 0);
      chk("t2_rst_y",  m_y, 16);
      chk("t2_rst_hs", m_hs, 0);
      @(negedge clk);
      @(negedge clk);
      chk("t2_rst_fc", m_fc, 0);
      chk("t2_rst_c",  m_c, 128);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("t2_fs_after_release", m_fs, 1);
      chk("t2_fc_after_release", m_fc, 0);
      gap = 0;
      for (int i = 1; i <= 400; i++) begin
         @(posedge clk); #1;
         if (m_fs === 1'b1) begin
            gap = i;
            break;
         end
      end
      chk("t2_fs_period", gap, 192);

      // Colour bars
      @(negedge clk);
      mode = 2'd1;
      wait_fs(ok);
      capture_frame();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t3_bar_y[%0d]", i), cap_y[i], exp_bar_y[i]);
         chk($sformatf("t3_bar_c[%0d]", i), cap_c[i], exp_bar_c[i]);
      end

      // Mode change mid-frame: 0 -> 3 at v_cnt=1
      @(negedge clk);
      mode = 2'd0;
      wait_fs(ok);
      wait_fs(ok);
      repeat (30) @(negedge clk);
      mode = 2'd3;
      solid_n = 0;
      solid_bad = 0;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk); #1;
         if (m_de === 1'b1) begin
            solid_n++;
            if (m_y !== 8'h50) solid_bad++;
         end
      end
      chk("t4_solid_seen", solid_n, 42);
      chk("t4_solid_bad",  solid_bad, 0);
      capture_frame();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t4_chk_line0[%0d]", i), cap_y[i], exp_chk0[i]);
         chk($sformatf("t4_chk_line2[%0d]", i), cap_y[32 + i], exp_chk2[i]);
      end
      chk("t4_chk_chroma", cap_c[1], 128);

      // Moving ramp and frame counter wrap
      @(negedge clk);
      mode  = 2'd2;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wait_fs(ok);
         chk($sformatf("t5_fc[%0d]", k),    m_fc, k);
         chk($sformatf("t5_fc2[%0d]", k),   f_fc, k % 4);
         chk($sformatf("t5_y_x0[%0d]", k),  m_y, k);
         @(posedge clk); #1;
         chk($sformatf("t5_y_x1[%0d]", k),  m_y, k + 1);
         chk($sformatf("t5_f2_y_x1[%0d]", k), f_y, (k % 4) + 1);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hdmi_timing_pattern_gen.md
Name: hdmi_timing_pattern_gen

Overview:
- Parametrised video timing generator and test-pattern source for the HDMI transmitter path.
- Supersedes the fixed-format HDMI test generator: resolution, porches, sync widths and sync polarity are parameters.
- Adds a runtime-selectable pattern mode, applied only at frame boundaries, plus frame-start and frame-count outputs.
- Output is YCbCr 4:2:2, 8-bit Y and multiplexed Cb/Cr, feeding the top-level 24-bit HDMI data bus.

Parameters:
H_ACTIVE, 1920, active pixels per line (even, ≥16)
H_FP, 88, horizontal front porch, pixels
H_SYNC, 44, hsync width, pixels
H_BP, 148, horizontal back porch, pixels
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch, lines
V_SYNC, 5, vsync width, lines
V_BP, 36, vertical back porch, lines
HS_POL, 1, hsync asserted level
VS_POL, 1, vsync asserted level
CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels/lines
FCNT_W, 16, frame counter width

Ports:
pixel_clk  in  1  pixel clock, all logic on rising edge
reset  in  1  synchronous reset, active-high
mode  in  2  pattern select: 0 solid, 1 colour bars, 2 moving ramp, 3 checkerboard
solid_y  in  8  Y value for mode 0
solid_cb  in  8  Cb value for mode 0
solid_cr  in  8  Cr value for mode 0
data_enable  out  1  active-video qualifier
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
data_Y  out  8  luma
data_Cb_Cr  out  8  Cb on even active pixels, Cr on odd
frame_start  out  1  one-cycle pulse coincident with the first active pixel of a frame
frame_cnt  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W

Behaviour:
- Counters: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps 0..V_TOTAL-1.
- Region decode, evaluated on counter values:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC on every line.
  - vsync asserted for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC; edges align with h_cnt==0.
- Latency: all outputs registered, exactly 1 cycle after the counter state that produced them. Sync, enable and data stay mutually aligned.
- Blanking (data_enable=0): data_Y=8'h10, data_Cb_Cr=8'h80.
- Mode latch: mode is sampled into mode_q only when h_cnt==0 && v_cnt==0. Changes mid-frame have no visible effect until the next frame.
- Patterns, for active pixel x=h_cnt, y=v_cnt:
  - mode 0: Y=solid_y; Cb/Cr=solid_cb/solid_cr.
  - mode 1: 8 bars of width H_ACTIVE/8, left to right, as (Y,Cb,Cr): (180,128,128) (162,44,142) (131,156,44) (112,72,58) (84,184,198) (65,100,212) (35,212,114) (16,128,128).
    - Bar index comes from a bar-width counter, not a divider. It restarts at x=0.
    - A residual H_ACTIVE mod 8 falls into the last bar.
  - mode 2: Y=(x[7:0]+frame_cnt[7:0]) mod 256; Cb=Cr=8'h80.
  - mode 3: Y=(x[CHK_LOG2]^y[CHK_LOG2]) ? 235 : 16; Cb=Cr=8'h80.
- Chroma: data_Cb_Cr = Cb when x[0]==0, else Cr.
  - Both values are taken from the even pixel of the pair, held for the odd pixel, so a bar edge never splits a pair.
- frame_start: high for the single cycle in which the x=0,y=0 pixel is output.
- frame_cnt: increments by 1 in the cycle after the last pixel of the frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1) is processed.
- Reset: synchronous, takes effect on the clock edge and overrides everything, including mid-line or mid-frame.
  - h_cnt=0, v_cnt=0, mode_q=0, frame_cnt=0.
  - data_enable=0, hsync=~HS_POL, vsync=~VS_POL, data_Y=8'h10, data_Cb_Cr=8'h80, frame_start=0.
  - The first cycle after reset release processes h_cnt=0, v_cnt=0. mode is sampled on that cycle, and frame_start follows one cycle later.

Test Plan:
Bench parameters: H_ACTIVE=16, H_FP=2, H_SYNC=4, H_BP=2 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); CHK_LOG2=1; POL=1.
1. Timing: run 2 frames. Expect:
   - data_enable high 16 cycles per line on lines 0-3, 64 cycles per frame.
   - hsync high 4 cycles starting 18 cycles after each line start.
   - vsync high lines 5-6.
   - Frame period 192 cycles.
2. Reset: assert reset at mid-frame (h_cnt=10, v_cnt=2) for 3 cycles. Expect:
   - Outputs at reset values while reset is high.
   - frame_start on the 2nd cycle after release, frame_cnt=0.
   - Next frame_start 192 cycles later.
3. Colour bars: mode=1, bar width 2. Expect:
   - Active line Y sequence 180,180,162,162,...,16,16.
   - Cb_Cr sequence 128,128,44,142,156,44,72,58,184,198,100,212,212,114,128,128.
4. Mode change mid-frame: mode 0→3 at v_cnt=1. Expect:
   - Rest of the frame still solid_y.
   - Next frame line 0 Y=16,16,235,235,…; line 2 Y=235,235,16,16,….
5. Ramp and counter: mode=2. Expect:
   - Frame n pixel x has Y=(x+n) mod 256.
   - frame_cnt steps by exactly 1 per frame.
   - FCNT_W=2 wraps 3→0.
6. Polarity: HS_POL=0, VS_POL=0. Expect hsync/vsync idle high and pulse low with identical timing to test 1.
